// File: rtl/delay_meas_if.sv
// rtl/delay_meas_if.sv - user-pin and delay-element signals of the delay-measurement sequencer
interface delay_meas_if #(
    parameter int CNT_W    = 8,
    parameter int LOG_REPS = 2
);
    logic                      start;
    logic                      sense;
    logic                      launch;
    logic                      busy;
    logic                      done;
    logic                      timeout;
    logic [CNT_W+LOG_REPS-1:0] result;
    logic [CNT_W-1:0]          last;

    modport master (
        output start, sense,
        input  launch, busy, done, timeout, result, last
    );

    modport slave (
        input  start, sense,
        output launch, busy, done, timeout, result, last
    );
endinterface

// File: rtl/delay_meas_ctrl.sv
// rtl/delay_meas_ctrl.sv - launches edges into a delay element and accumulates synchronized return latencies
module delay_meas_ctrl #(
    parameter int CNT_W      = 8,
    parameter int LOG_REPS   = 2,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 200,
    parameter int INVERT     = 1
) (
    input  logic         clk,
    input  logic         rst,
    delay_meas_if.slave  bus
);
    localparam int SUM_W = CNT_W + LOG_REPS;
    localparam int REP_W = (LOG_REPS > 0) ? LOG_REPS : 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << LOG_REPS) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic             INV      = (INVERT != 0);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic             launch;
    logic             s1, s2;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum;
    logic [REP_W-1:0] rep;
    logic [SET_W-1:0] settle;
    logic             timeout;
    logic [SUM_W-1:0] result;
    logic [CNT_W-1:0] last;

    logic             clr_run, settle_end, take, abort, cnt_inc;
    logic             match;
    logic [SUM_W-1:0] sum_add;

    // launch already holds the post-toggle level while in WAIT
    assign match   = (s2 == (launch ^ INV));
    assign sum_add = sum + SUM_W'(count);

    always_comb begin
        state_nxt  = state;
        clr_run    = 1'b0;
        settle_end = 1'b0;
        take       = 1'b0;
        abort      = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clr_run   = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle == SET_LAST) begin
                    settle_end = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (match) begin
                    take      = 1'b1;
                    state_nxt = (rep == REP_LAST) ? DONE : SETTLE;
                end else if (count == CNT_MAX) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            launch  <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            count   <= '0;
            sum     <= '0;
            rep     <= '0;
            settle  <= '0;
            timeout <= 1'b0;
            result  <= '0;
            last    <= '0;
        end else begin
            state <= state_nxt;
            s1    <= bus.sense;
            s2    <= s1;
            if (clr_run) begin
                sum     <= '0;
                rep     <= '0;
                settle  <= '0;
                timeout <= 1'b0;
            end
            if (state == SETTLE)
                settle <= settle_end ? '0 : settle + 1'b1;
            if (settle_end) begin
                launch <= ~launch;
                count  <= '0;
            end
            if (cnt_inc)
                count <= count + 1'b1;
            // result is loaded on the edge entering DONE so it is valid alongside done
            if (take) begin
                sum  <= sum_add;
                last <= count;
                rep  <= rep + 1'b1;
                if (state_nxt == DONE)
                    result <= sum_add;
            end
            if (abort) begin
                timeout <= 1'b1;
                result  <= sum;
            end
        end
    end

    assign bus.launch  = launch;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.timeout = timeout;
    assign bus.result  = result;
    assign bus.last    = last;
endmodule

// File: tb/tb_delay_meas_ctrl.sv
// tb/tb_delay_meas_ctrl.sv - directed bench for delay_meas_ctrl with two parameter sets
module tb_delay_meas_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    delay_meas_if #(.CNT_W(8), .LOG_REPS(2)) ifa ();
    delay_meas_if #(.CNT_W(8), .LOG_REPS(0)) ifb ();

    delay_meas_ctrl #(
        .CNT_W(8), .LOG_REPS(2), .SETTLE_CYC(4), .TIMEOUT(200), .INVERT(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    delay_meas_ctrl #(
        .CNT_W(8), .LOG_REPS(0), .SETTLE_CYC(1), .TIMEOUT(200), .INVERT(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // delay-element models: 0 = combinational inverter, 1 = 10-flop inverter, 2 = stuck
    int         sense_mode = 0;
    logic       stuck_val  = 1'b0;
    logic [9:0] dly_a      = '0;
    logic [2:0] dly_b      = '0;

    always @(posedge clk) dly_a <= {dly_a[8:0], ~ifa.launch};
    always @(posedge clk) dly_b <= {dly_b[1:0], ifb.launch};

    assign ifa.sense = (sense_mode == 0) ? ~ifa.launch :
                       (sense_mode == 1) ? dly_a[9] : stuck_val;
    assign ifb.sense = dly_b[2];

    int   done_cnt_a = 0;
    int   tog_a      = 0;
    logic launch_prev_a = 1'b0;

    always @(negedge clk) begin
        if (ifa.done) done_cnt_a <= done_cnt_a + 1;
        if (ifa.launch !== launch_prev_a) tog_a <= tog_a + 1;
        launch_prev_a <= ifa.launch;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // called on a negedge; returns negedges from raising start until done is seen
    task automatic start_run(input int which, input int budget, output int cyc);
        if (which == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
        @(negedge clk);
        if (which == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
        cyc = 1;
        while (!((which == 0) ? ifa.done : ifb.done) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc, gap, idle, d0, t0;
        logic lvl;

        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy",    ifa.busy,    0);
        check("rst_done",    ifa.done,    0);
        check("rst_launch",  ifa.launch,  0);
        check("rst_timeout", ifa.timeout, 0);
        check("rst_result",  ifa.result,  0);
        check("rst_last",    ifa.last,    0);
        check("rst_b_busy",  ifb.busy,    0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // zero-delay inverting path
        d0 = done_cnt_a;
        start_run(0, 100, cyc);
        check("zd_latency", cyc,         29);
        check("zd_result",  ifa.result,  8);
        check("zd_last",    ifa.last,    2);
        check("zd_timeout", ifa.timeout, 0);
        check("zd_busy_in_done", ifa.busy, 1);
        @(negedge clk);
        check("zd_busy_after", ifa.busy, 0);
        check("zd_done_after", ifa.done, 0);
        repeat (2) @(negedge clk);
        check("zd_done_pulses", done_cnt_a - d0, 1);
        check("zd_launch_level", ifa.launch, 0);

        // ten-flop inverting path
        sense_mode = 1;
        repeat (15) @(negedge clk);
        lvl = ifa.launch;
        t0  = tog_a;
        start_run(0, 200, cyc);
        check("reg_latency", cyc,        69);
        check("reg_result",  ifa.result, 48);
        check("reg_last",    ifa.last,   12);
        repeat (2) @(negedge clk);
        check("reg_toggles", tog_a - t0, 4);
        check("reg_level",   ifa.launch, lvl);

        // start pulses while running are ignored
        sense_mode = 0;
        repeat (3) @(negedge clk);
        d0 = done_cnt_a;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        cyc = 1;
        check("busy_after_accept", ifa.busy, 1);
        while (!ifa.done && cyc < 100) begin
            ifa.start = (ifa.busy && (cyc % 3 == 0));
            @(negedge clk);
            cyc++;
        end
        ifa.start = 1'b0;
        check("ign_latency", cyc,        29);
        check("ign_result",  ifa.result, 8);
        repeat (3) @(negedge clk);
        check("ign_busy",  ifa.busy, 0);
        check("ign_pulses", done_cnt_a - d0, 1);

        // start held high: back-to-back runs with one idle cycle
        ifa.start = 1'b1;
        cyc = 0;
        while (!ifa.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_first_latency", cyc, 29);
        gap  = 0;
        idle = 0;
        do begin
            @(negedge clk);
            gap++;
            if (!ifa.busy) idle++;
        end while (!ifa.done && gap < 100);
        ifa.start = 1'b0;
        check("hold_gap",  gap,  30);
        check("hold_idle", idle, 1);
        repeat (3) @(negedge clk);
        check("hold_stop", ifa.busy, 0);

        // reset during WAIT of sample 2
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy_before", ifa.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy",    ifa.busy,    0);
        check("mid_launch",  ifa.launch,  0);
        check("mid_result",  ifa.result,  0);
        check("mid_last",    ifa.last,    0);
        check("mid_timeout", ifa.timeout, 0);
        check("mid_done",    ifa.done,    0);
        @(negedge clk);
        start_run(0, 100, cyc);
        check("post_rst_latency", cyc,        29);
        check("post_rst_result",  ifa.result, 8);
        check("post_rst_last",    ifa.last,   2);

        // stuck sense: hold the pre-launch expected level after a fresh reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stuck_val  = ~ifa.launch ^ 1'b0;
        sense_mode = 2;
        repeat (3) @(negedge clk);
        d0 = done_cnt_a;
        start_run(0, 400, cyc);
        check("stuck_latency", cyc,         206);
        check("stuck_timeout", ifa.timeout, 1);
        check("stuck_result",  ifa.result,  0);
        check("stuck_last",    ifa.last,    0);
        @(negedge clk);
        check("stuck_busy_after", ifa.busy, 0);
        repeat (2) @(negedge clk);
        check("stuck_pulses", done_cnt_a - d0, 1);
        check("stuck_timeout_sticky", ifa.timeout, 1);

        // next accepted start clears timeout
        sense_mode = 0;
        repeat (3) @(negedge clk);
        start_run(0, 100, cyc);
        check("clr_timeout", ifa.timeout, 0);
        check("clr_result",  ifa.result,  8);

        // non-inverting 3-flop path, single sample, one settle cycle
        repeat (3) @(negedge clk);
        start_run(1, 50, cyc);
        check("b_latency", cyc,         8);
        check("b_result",  ifb.result,  5);
        check("b_last",    ifb.last,    5);
        check("b_timeout", ifb.timeout, 0);
        repeat (6) @(negedge clk);
        start_run(1, 50, cyc);
        check("b2_latency", cyc,        8);
        check("b2_result",  ifb.result, 5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
